// File: rtl/uart_fifo_reg_bank_pkg.sv
// Shared register map, STATUS/CTRL bit positions and the STATUS layout
// for the UART FIFO register bank.
package uart_reg_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_TX_FULL      = 3;
  localparam int ST_RX_OVF       = 4;
  localparam int ST_TX_OVF       = 5;

  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;
  localparam int CTRL_IRQ_EN   = 4;

  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] tx_count;
    logic [7:0] rx_count;
    logic [1:0] rsvd_lo;
    logic       tx_ovf;
    logic       rx_ovf;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_full;
    logic       rx_not_empty;
  } status_t;

endpackage

// File: rtl/uart_fifo_reg_bank_if.sv
// Register-access bus between the AXI4-Lite slave front end and the bank.
interface uart_fifo_reg_bank_if;
  logic        wr_amba;
  logic [31:0] addr_wc;
  logic [31:0] data_in;
  logic [3:0]  strb;
  logic        rd_amba;
  logic [31:0] addr_rc;
  logic [31:0] data_out;

  modport master (output wr_amba, addr_wc, data_in, strb, rd_amba, addr_rc,
                  input  data_out);
  modport slave  (input  wr_amba, addr_wc, data_in, strb, rd_amba, addr_rc,
                  output data_out);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with count, flush and zero-when-empty read head.
// Push when full and pop when empty are ignored; flush overrides both.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; pointers and count define validity, and
  // leaving it out lets the array map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_reg_bank.sv
// Register bank between the AXI4-Lite slave and the UART datapath:
// TX/RX FIFOs, STATUS with sticky overflow flags, CTRL with flush and irq enable.
module uart_fifo_reg_bank
  import uart_reg_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_fifo_reg_bank_if.slave  bus,
  input  logic [DATA_W-1:0]    rx_data,
  input  logic                 rxValid,
  output logic                 rxReady,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 txValid,
  input  logic                 txReady,
  output logic                 irq
);

  logic [1:0] wr_idx, rd_idx;
  logic       wr_lane0;
  logic       tx_push, tx_pop, tx_flush, tx_empty, tx_full;
  logic       rx_push, rx_pop, rx_flush, rx_empty, rx_full;
  logic [DATA_W-1:0] rx_rdata;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic       rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic       irq_en_q, irq_en_d, irq_q, irq_d;
  status_t    status;
  logic       unused_bits;

  assign wr_idx   = bus.addr_wc[3:2];
  assign rd_idx   = bus.addr_rc[3:2];
  assign wr_lane0 = bus.wr_amba && bus.strb[0];

  assign tx_push  = wr_lane0 && (wr_idx == REG_TXDATA);
  assign tx_pop   = txValid && txReady;
  assign tx_flush = wr_lane0 && (wr_idx == REG_CTRL) && bus.data_in[CTRL_TX_FLUSH];
  assign rx_push  = rxValid && rxReady;
  assign rx_pop   = bus.rd_amba && (rd_idx == REG_RXDATA) && !rx_empty;
  assign rx_flush = wr_lane0 && (wr_idx == REG_CTRL) && bus.data_in[CTRL_RX_FLUSH];

  assign txValid = !tx_empty;
  assign rxReady = !rx_full;
  assign irq     = irq_q;

  assign unused_bits = ^{bus.addr_wc[31:4], bus.addr_wc[1:0], bus.addr_rc[31:4],
                         bus.addr_rc[1:0], bus.data_in[31:DATA_W], bus.strb[3:1]};

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .wdata(bus.data_in[DATA_W-1:0]), .rdata(tx_data),
    .empty(tx_empty), .full(tx_full), .count(tx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .wdata(rx_data), .rdata(rx_rdata),
    .empty(rx_empty), .full(rx_full), .count(rx_count)
  );

  // Overflow set is applied after the W1C so a same-cycle event survives.
  always_comb begin
    rx_ovf_d = rx_ovf_q;
    tx_ovf_d = tx_ovf_q;
    irq_en_d = irq_en_q;
    if (wr_lane0 && (wr_idx == REG_STATUS)) begin
      if (bus.data_in[ST_RX_OVF]) rx_ovf_d = 1'b0;
      if (bus.data_in[ST_TX_OVF]) tx_ovf_d = 1'b0;
    end
    if (wr_lane0 && (wr_idx == REG_CTRL)) irq_en_d = bus.data_in[CTRL_IRQ_EN];
    if (rxValid && !rxReady) rx_ovf_d = 1'b1;
    if (tx_push && tx_full)  tx_ovf_d = 1'b1;
    irq_d = irq_en_q && (!rx_empty || rx_ovf_q || tx_ovf_q);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    status              = '0;
    status.rx_not_empty = !rx_empty;
    status.rx_full      = rx_full;
    status.tx_empty     = tx_empty;
    status.tx_full      = tx_full;
    status.rx_ovf       = rx_ovf_q;
    status.tx_ovf       = tx_ovf_q;
    status.rx_count     = 8'(rx_count);
    status.tx_count     = 8'(tx_count);
  end

  // NOTE: every path of this mux assigns data_out, so no latch is inferred.
  always_comb begin
    bus.data_out = '0;
    unique case (rd_idx)
      REG_TXDATA: bus.data_out = '0;
      REG_RXDATA: bus.data_out = 32'(rx_rdata);
      REG_STATUS: bus.data_out = status;
      REG_CTRL:   bus.data_out = 32'(irq_en_q) << CTRL_IRQ_EN;
      default:    bus.data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_reg_bank.sv
// Directed bench for uart_fifo_reg_bank with TX/RX scoreboards.
module tb_uart_fifo_reg_bank;
  import uart_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rxValid, rxReady;
  logic [7:0] tx_data;
  logic       txValid, txReady;
  logic       irq;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  uart_fifo_reg_bank_if bus ();

  uart_fifo_reg_bank #(.DATA_W(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .rx_data(rx_data), .rxValid(rxValid), .rxReady(rxReady),
    .tx_data(tx_data), .txValid(txValid), .txReady(txReady), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; drive time is 1 unit after the edge, strobes are one-shot.
  task automatic step();
    @(posedge clk);
    #1;
    bus.wr_amba = 1'b0;
    bus.rd_amba = 1'b0;
    bus.strb    = 4'h0;
    rxValid     = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
    bus.wr_amba = 1'b1;
    bus.addr_wc = {28'h0, idx, 2'b00};
    bus.data_in = d;
    bus.strb    = s;
    if (idx == REG_TXDATA && s[0]) begin
      if (tx_q.size() < 16) tx_q.push_back(d[7:0]);
    end
    step();
  endtask

  task automatic reg_read(input logic [1:0] idx, input logic commit, output logic [31:0] d);
    bus.addr_rc = {28'h0, idx, 2'b00};
    #1;
    d = bus.data_out;
    bus.rd_amba = commit;
    step();
  endtask

  task automatic rx_send(input logic [7:0] ch);
    rxValid = 1'b1;
    rx_data = ch;
    if (rx_q.size() < 16) rx_q.push_back(ch);
    step();
  endtask

  initial begin
    logic [31:0] d;
    int n;
    rst = 1'b1;
    bus.wr_amba = 1'b0; bus.rd_amba = 1'b0; bus.strb = 4'h0;
    bus.addr_wc = '0; bus.addr_rc = '0; bus.data_in = '0;
    rx_data = '0; rxValid = 1'b0; txReady = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Reset mid-traffic with 5 TX entries queued.
    for (int i = 1; i <= 5; i++) reg_write(REG_TXDATA, 32'(i), 4'h1);
    reg_read(REG_STATUS, 1'b0, d);
    check("pre_reset_status", d, 32'h0005_0000);
    rst = 1'b1;
    #1;
    check("rst_txValid", 32'(txValid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rxReady", 32'(rxReady), 32'h1);
    bus.addr_rc = {28'h0, REG_STATUS, 2'b00};
    #1;
    check("rst_status", bus.data_out, 32'h0000_0004);
    tx_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // TX ordering and overflow on the 17th write.
    for (int i = 1; i <= 17; i++) reg_write(REG_TXDATA, 32'h100 | 32'(i), 4'h1);
    reg_read(REG_STATUS, 1'b0, d);
    check("tx_full_status", d, 32'h0010_0028);
    reg_read(REG_TXDATA, 1'b0, d);
    check("txdata_reads_zero", d, 32'h0);
    txReady = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && tx_q.size() > 0; k++) begin
      if (txValid) begin
        check("tx_data_order", 32'(tx_data), 32'(tx_q.pop_front()));
        n++;
      end
      step();
    end
    check("tx_drain_count", 32'(n), 32'd16);
    check("tx_idle_after_drain", 32'(txValid), 32'h0);
    reg_write(REG_STATUS, 32'h20, 4'h0);
    reg_read(REG_STATUS, 1'b0, d);
    check("w1c_strb0_ignored", d, 32'h0000_0024);
    reg_write(REG_STATUS, 32'h20, 4'h1);
    reg_read(REG_STATUS, 1'b0, d);
    check("tx_ovf_cleared", d, 32'h0000_0004);

    // RX fill, overflow and drain.
    for (int i = 0; i < 16; i++) rx_send(8'hA0 + 8'(i));
    check("rxReady_full", 32'(rxReady), 32'h0);
    rx_send(8'hB0);
    reg_read(REG_STATUS, 1'b0, d);
    check("rx_ovf_status", d, 32'h0000_1017);
    while (rx_q.size() > 0) begin
      reg_read(REG_RXDATA, 1'b1, d);
      check("rx_read_order", d, 32'(rx_q.pop_front()));
    end
    reg_read(REG_RXDATA, 1'b1, d);
    check("rx_empty_read", d, 32'h0);
    reg_write(REG_STATUS, 32'h10, 4'h1);

    // Simultaneous push and pop keeps the count.
    for (int i = 0; i < 3; i++) rx_send(8'hC0 + 8'(i));
    rxValid = 1'b1;
    rx_data = 8'hC3;
    rx_q.push_back(8'hC3);
    reg_read(REG_RXDATA, 1'b1, d);
    check("rx_pushpop_head", d, 32'(rx_q.pop_front()));
    reg_read(REG_STATUS, 1'b0, d);
    check("rx_pushpop_count", d, 32'h0000_0305);
    while (rx_q.size() > 0) begin
      reg_read(REG_RXDATA, 1'b1, d);
      check("rx_pushpop_order", d, 32'(rx_q.pop_front()));
    end

    // Set beats clear on rx_ovf; unmapped lane has no effect.
    for (int i = 0; i < 16; i++) rx_send(8'hD0 + 8'(i));
    rxValid = 1'b1;
    rx_data = 8'hEE;
    reg_write(REG_STATUS, 32'h10, 4'h1);
    reg_read(REG_STATUS, 1'b0, d);
    check("ovf_set_wins", d, 32'h0000_1017);
    reg_write(REG_STATUS, 32'h10, 4'h2);
    reg_read(REG_STATUS, 1'b0, d);
    check("unmapped_lane", d, 32'h0000_1017);
    reg_write(REG_STATUS, 32'h10, 4'h1);
    reg_write(REG_CTRL, 32'h02, 4'h1);
    rx_q.delete();
    reg_read(REG_STATUS, 1'b0, d);
    check("rx_flush_status", d, 32'h0000_0004);

    // Interrupt behaviour.
    reg_write(REG_CTRL, 32'h10, 4'h1);
    reg_read(REG_CTRL, 1'b0, d);
    check("ctrl_readback", d, 32'h10);
    check("irq_idle", 32'(irq), 32'h0);
    rx_send(8'h5A);
    check("irq_latency", 32'(irq), 32'h0);
    step();
    check("irq_rx", 32'(irq), 32'h1);
    reg_read(REG_RXDATA, 1'b1, d);
    check("irq_rx_data", d, 32'(rx_q.pop_front()));
    step();
    check("irq_rx_clear", 32'(irq), 32'h0);
    txReady = 1'b0;
    for (int i = 0; i < 17; i++) reg_write(REG_TXDATA, 32'h40 + 32'(i), 4'h1);
    step();
    check("irq_tx_ovf", 32'(irq), 32'h1);
    reg_write(REG_STATUS, 32'h20, 4'h1);
    step();
    check("irq_w1c_clear", 32'(irq), 32'h0);

    // Flush both FIFOs; an RX push in the flush cycle is discarded.
    reg_write(REG_CTRL, 32'h11, 4'h1);
    tx_q.delete();
    check("tx_flush_valid", 32'(txValid), 32'h0);
    for (int i = 0; i < 7; i++) reg_write(REG_TXDATA, 32'h60 + 32'(i), 4'h1);
    for (int i = 0; i < 4; i++) rx_send(8'h70 + 8'(i));
    reg_read(REG_STATUS, 1'b0, d);
    check("pre_flush_status", d, 32'h0007_0401);
    rxValid = 1'b1;
    rx_data = 8'h99;
    reg_write(REG_CTRL, 32'h13, 4'h1);
    tx_q.delete();
    rx_q.delete();
    check("flush_txValid", 32'(txValid), 32'h0);
    reg_read(REG_STATUS, 1'b0, d);
    check("flush_status", d, 32'h0000_0004);
    reg_read(REG_CTRL, 1'b0, d);
    check("flush_ctrl_read", d, 32'h10);
    check("flush_irq", 32'(irq), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
